video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter PIX_DIV, default 2: clk cycles per pixel, legal range 1..16.
REQ-002 Parameter H_TOTAL, default 384: pixels per line.
REQ-003 Parameter H_ACTIVE, default 256: visible pixels per line.
REQ-004 Parameter H_SYNC_START, default 288: first hsync pixel.
REQ-005 Parameter H_SYNC_LEN, default 32: hsync width in pixels.
REQ-006 Parameter V_TOTAL, default 264: lines per frame.
REQ-007 Parameter V_ACTIVE, default 224: visible lines.
REQ-008 Parameter V_SYNC_START, default 240: first vsync line.
REQ-009 Parameter V_SYNC_LEN, default 8: vsync height in lines.
REQ-010 Parameters HW, default 10, and VW, default 9: htiming and vtiming widths.
REQ-011 clk  in  1  system clock, all state on rising edge.
REQ-012 rst_n  in  1  reset, asynchronous, active-high.
REQ-013 ena  in  1  run enable; low freezes all timing state.
REQ-014 irq_ack  in  1  vblank interrupt acknowledge.
REQ-015 pixel_ce  out  1  one-clk pixel strobe.
REQ-016 htiming  out  HW  horizontal pixel counter.
REQ-017 vtiming  out  VW  line counter.
REQ-018 hsync, vsync  out  1 each  active-low syncs.
REQ-019 hblank, vblank  out  1 each  blanking flags.
REQ-020 video_valid  out  1  pixel visible.
REQ-021 frame_start  out  1  one-clk pulse at (0,0).
REQ-022 vblk_irq  out  1  vblank interrupt, level.

Function
REQ-023 Divider counts 0..PIX_DIV-1 while ena=1; pixel_ce=1 exactly in the clk where divider=PIX_DIV-1 and ena=1; PIX_DIV=1 gives pixel_ce=ena.
REQ-024 On pixel_ce: htiming increments; H_TOTAL-1 wraps to 0 and increments vtiming; V_TOTAL-1 with h wrap wraps vtiming to 0.
REQ-025 ena=0: divider, htiming, vtiming held; pixel_ce=0; frame_start=0; irq set suppressed; ack still honoured.
REQ-026 Decode combinational from the counter registers: hblank = htiming>=H_ACTIVE; vblank = vtiming>=V_ACTIVE.
REQ-027 hsync=0 iff H_SYNC_START <= htiming < H_SYNC_START+H_SYNC_LEN; vsync likewise on vtiming.
REQ-028 video_valid = running & ~hblank & ~vblank; running is a flop cleared by reset and set on the first clk after reset release.
REQ-029 frame_start=1 for the single clk following the pixel_ce that wraps both counters to 0.
REQ-030 Elaboration error if H_ACTIVE>=H_TOTAL, V_ACTIVE>=V_TOTAL, a sync window exceeds its total, or a total exceeds 2**HW / 2**VW.

Reset
REQ-031 While rst_n high: divider=0, htiming=0, vtiming=0, pixel_ce=0, hsync=1, vsync=1, hblank=0, vblank=0, video_valid=0, frame_start=0, vblk_irq=0, running=0.
REQ-032 Reset mid-frame aborts immediately; the first pixel_ce after release occurs PIX_DIV clks later (ena=1).

Configuration
REQ-033 With VTIMING_IRQ_EN defined: vblk_irq sets on the pixel_ce moving vtiming to V_ACTIVE with htiming to 0, and clears on a clk with irq_ack=1; simultaneous set and ack leaves it set.
REQ-034 Without VTIMING_IRQ_EN: vblk_irq is constant 0, irq_ack ignored, no irq flop.

Verification
REQ-035 Defaults, ena=1 after reset -> pixel_ce every 2nd clk; htiming 383->0 after 768 clks; frame_start period 202752 clks.
REQ-036 Defaults, htiming 287->288 -> hsync falls; 319->320 -> hsync rises; hblank=1 for htiming 256..383.
REQ-037 VTIMING_IRQ_EN, vtiming 223->224 -> vblk_irq=1 held; irq_ack one clk -> 0 next clk; ack on set clk -> stays 1.
REQ-038 ena low 100 clks at htiming=100 -> htiming stays 100, pixel_ce=0; resumes 101 after ena high.
REQ-039 rst_n pulse at vtiming=150 -> all outputs at reset values during pulse; counters restart at (0,0); video_valid=1 one clk after release.
REQ-040 PIX_DIV=1, H_TOTAL=8, H_ACTIVE=4, V_TOTAL=4, V_ACTIVE=2 -> frame_start every 32 clks; video_valid high 8 of 32 clks.

Source files
------------

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - Raster timing generator: pixel divider, h/v counters, sync/blank decode.
// Define VTIMING_IRQ_EN to build the vblank interrupt flop; otherwise vblk_irq is tied low.
module video_timing_gen #(
   parameter int PIX_DIV      = 2,
   parameter int H_TOTAL      = 384,
   parameter int H_ACTIVE     = 256,
   parameter int H_SYNC_START = 288,
   parameter int H_SYNC_LEN   = 32,
   parameter int V_TOTAL      = 264,
   parameter int V_ACTIVE     = 224,
   parameter int V_SYNC_START = 240,
   parameter int V_SYNC_LEN   = 8,
   parameter int HW           = 10,
   parameter int VW           = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          irq_ack,
   output logic          pixel_ce,
   output logic [HW-1:0] htiming,
   output logic [VW-1:0] vtiming,
   output logic          hsync,
   output logic          vsync,
   output logic          hblank,
   output logic          vblank,
   output logic          video_valid,
   output logic          frame_start,
   output logic          vblk_irq
);

   localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

   if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
      $error("video_timing_gen: PIX_DIV must be 1..16");
   end
   if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL) begin : g_bad_active
      $error("video_timing_gen: active region must be smaller than total");
   end
   if (H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_sync
      $error("video_timing_gen: sync window exceeds total");
   end
   if (H_TOTAL > 2**HW || V_TOTAL > 2**VW) begin : g_bad_width
      $error("video_timing_gen: total does not fit counter width");
   end

   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          fs_q, fs_d;
   logic          running_q;
   logic          pix_tick;
   logic          h_wrap;
   logic          v_wrap;

   always_comb begin
      pix_tick = ena && (div_q == DIV_LAST);
      h_wrap   = (h_q == H_LAST);
      v_wrap   = (v_q == V_LAST);
      div_d    = div_q;
      h_d      = h_q;
      v_d      = v_q;
      fs_d     = 1'b0;
      if (ena) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
      if (pix_tick) begin
         if (h_wrap) begin
            h_d  = '0;
            v_d  = v_wrap ? '0 : v_q + VW'(1);
            fs_d = v_wrap;
         end else begin
            h_d = h_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         div_q     <= '0;
         h_q       <= '0;
         v_q       <= '0;
         fs_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         div_q     <= div_d;
         h_q       <= h_d;
         v_q       <= v_d;
         fs_q      <= fs_d;
         running_q <= 1'b1;
      end
   end

   // Reset gates the strobe so PIX_DIV=1 cannot leak ena through while held.
   assign pixel_ce    = pix_tick & ~rst_n;
   assign htiming     = h_q;
   assign vtiming     = v_q;
   assign hblank      = int'(h_q) >= H_ACTIVE;
   assign vblank      = int'(v_q) >= V_ACTIVE;
   assign hsync       = !(int'(h_q) >= H_SYNC_START && int'(h_q) < H_SYNC_START + H_SYNC_LEN);
   assign vsync       = !(int'(v_q) >= V_SYNC_START && int'(v_q) < V_SYNC_START + V_SYNC_LEN);
   assign video_valid = running_q & ~hblank & ~vblank;
   assign frame_start = fs_q & ena;

`ifdef VTIMING_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = irq_q;
      if (irq_ack) begin
         irq_d = 1'b0;
      end
      // Set beats a same-cycle acknowledge so a fresh vblank is never lost.
      if (pix_tick && h_wrap && int'(v_q) == V_ACTIVE - 1) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign vblk_irq = irq_q;
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign vblk_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - Self-checking bench for video_timing_gen (three parameter sets).
// Instance 0 uses defaults, instance 1 a tiny PIX_DIV=1 raster, instance 2 a PIX_DIV=3 raster.
`timescale 1ns/1ps
module tb_video_timing_gen;

`ifdef VTIMING_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   typedef struct { int pd, ht, ha, hss, hsl, vt, va, vss, vsl; } cfg_t;
   typedef struct { int e; bit run; bit fsf; bit irq; bit rst; } mst_t;
   typedef struct { int h, v; bit pce, hs, vs, hb, vb, vv, fs, irq; } exp_t;
   typedef struct { int adv; bit ena; int h, v; bit hs, vs, hb, vb, vv, fs; } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_v [3];
   logic ena_v [3];
   logic ack_v [3];

   logic       d_pce, d_hs, d_vs, d_hb, d_vb, d_vv, d_fs, d_irq;
   logic [9:0] d_h;
   logic [8:0] d_v;
   logic       a_pce, a_hs, a_vs, a_hb, a_vb, a_vv, a_fs, a_irq;
   logic [2:0] a_h;
   logic [1:0] a_v;
   logic       b_pce, b_hs, b_vs, b_hb, b_vb, b_vv, b_fs, b_irq;
   logic [3:0] b_h;
   logic [2:0] b_v;

   int   checks = 0;
   int   errors = 0;
   cfg_t cfg [3];
   mst_t st  [3];
   vec_t tbl [11];
   int   fs_cnt, vv_cnt, first_fs, last_fs;

   video_timing_gen u_d (
      .clk(clk), .rst_n(rst_v[0]), .ena(ena_v[0]), .irq_ack(ack_v[0]),
      .pixel_ce(d_pce), .htiming(d_h), .vtiming(d_v), .hsync(d_hs), .vsync(d_vs),
      .hblank(d_hb), .vblank(d_vb), .video_valid(d_vv), .frame_start(d_fs), .vblk_irq(d_irq)
   );

   video_timing_gen #(
      .PIX_DIV(1), .H_TOTAL(8), .H_ACTIVE(4), .H_SYNC_START(5), .H_SYNC_LEN(2),
      .V_TOTAL(4), .V_ACTIVE(2), .V_SYNC_START(3), .V_SYNC_LEN(1), .HW(3), .VW(2)
   ) u_a (
      .clk(clk), .rst_n(rst_v[1]), .ena(ena_v[1]), .irq_ack(ack_v[1]),
      .pixel_ce(a_pce), .htiming(a_h), .vtiming(a_v), .hsync(a_hs), .vsync(a_vs),
      .hblank(a_hb), .vblank(a_vb), .video_valid(a_vv), .frame_start(a_fs), .vblk_irq(a_irq)
   );

   video_timing_gen #(
      .PIX_DIV(3), .H_TOTAL(10), .H_ACTIVE(6), .H_SYNC_START(7), .H_SYNC_LEN(2),
      .V_TOTAL(6), .V_ACTIVE(4), .V_SYNC_START(4), .V_SYNC_LEN(1), .HW(4), .VW(3)
   ) u_b (
      .clk(clk), .rst_n(rst_v[2]), .ena(ena_v[2]), .irq_ack(ack_v[2]),
      .pixel_ce(b_pce), .htiming(b_h), .vtiming(b_v), .hsync(b_hs), .vsync(b_vs),
      .hblank(b_hb), .vblank(b_vb), .video_valid(b_vv), .frame_start(b_fs), .vblk_irq(b_irq)
   );

   // Reference: everything follows from the count of enabled clocks since reset.
   function automatic mst_t model_edge(input cfg_t c, input mst_t s, input bit ena, input bit ack);
      mst_t n;
      bit   tick;
      n = s;
      if (s.rst) return s;
      tick  = ena && (s.e % c.pd == c.pd - 1);
      n.run = 1'b1;
      if (ena) n.e = s.e + 1;
      n.fsf = tick && ((n.e / c.pd) % (c.ht * c.vt) == 0);
      if (ack) n.irq = 1'b0;
      if (IRQ_EN && tick && ((n.e / c.pd) % (c.ht * c.vt) == c.va * c.ht)) n.irq = 1'b1;
      return n;
   endfunction

   function automatic exp_t expect_out(input cfg_t c, input mst_t s, input bit ena);
      exp_t x;
      int   p;
      p     = s.e / c.pd;
      x.h   = p % c.ht;
      x.v   = (p / c.ht) % c.vt;
      x.pce = !s.rst && ena && (s.e % c.pd == c.pd - 1);
      x.hs  = !(x.h >= c.hss && x.h < c.hss + c.hsl);
      x.vs  = !(x.v >= c.vss && x.v < c.vss + c.vsl);
      x.hb  = x.h >= c.ha;
      x.vb  = x.v >= c.va;
      x.vv  = s.run && x.h < c.ha && x.v < c.va;
      x.fs  = s.fsf && ena;
      x.irq = s.irq;
      return x;
   endfunction

   function automatic exp_t obs(input int id);
      exp_t o;
      case (id)
         0: o = '{int'(d_h), int'(d_v), d_pce, d_hs, d_vs, d_hb, d_vb, d_vv, d_fs, d_irq};
         1: o = '{int'(a_h), int'(a_v), a_pce, a_hs, a_vs, a_hb, a_vb, a_vv, a_fs, a_irq};
         default: o = '{int'(b_h), int'(b_v), b_pce, b_hs, b_vs, b_hb, b_vb, b_vv, b_fs, b_irq};
      endcase
      return o;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input exp_t a, input exp_t e);
      chk({tag, ".htiming"}, a.h, e.h);
      chk({tag, ".vtiming"}, a.v, e.v);
      chk({tag, ".pixel_ce"}, int'(a.pce), int'(e.pce));
      chk({tag, ".hsync"}, int'(a.hs), int'(e.hs));
      chk({tag, ".vsync"}, int'(a.vs), int'(e.vs));
      chk({tag, ".hblank"}, int'(a.hb), int'(e.hb));
      chk({tag, ".vblank"}, int'(a.vb), int'(e.vb));
      chk({tag, ".video_valid"}, int'(a.vv), int'(e.vv));
      chk({tag, ".frame_start"}, int'(a.fs), int'(e.fs));
      chk({tag, ".vblk_irq"}, int'(a.irq), int'(e.irq));
   endtask

   task automatic cycle(input int id, input bit ena, input bit ack, input string tag);
      ena_v[id] = ena;
      ack_v[id] = ack;
      @(posedge clk);
      st[id] = model_edge(cfg[id], st[id], ena, ack);
      #1;
      cmp(tag, obs(id), expect_out(cfg[id], st[id], ena));
   endtask

   task automatic do_reset(input int id, input int n);
      rst_v[id] = 1'b1;
      ena_v[id] = 1'b1;
      ack_v[id] = 1'b0;
      st[id]    = '{0, 1'b0, 1'b0, 1'b0, 1'b1};
      #1;
      cmp($sformatf("rst%0d", id), obs(id), expect_out(cfg[id], st[id], 1'b1));
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         cmp($sformatf("rst%0d", id), obs(id), expect_out(cfg[id], st[id], 1'b1));
      end
      rst_v[id]  = 1'b0;
      st[id].rst = 1'b0;
      #1;
      cmp($sformatf("rel%0d", id), obs(id), expect_out(cfg[id], st[id], 1'b1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg[0] = '{2, 384, 256, 288, 32, 264, 224, 240, 8};
      cfg[1] = '{1, 8, 4, 5, 2, 4, 2, 3, 1};
      cfg[2] = '{3, 10, 6, 7, 2, 6, 4, 4, 1};
      //         adv ena  h  v hs vs hb vb vv fs
      tbl[0]  = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 0};
      tbl[2]  = '{4, 1, 5, 0, 0, 1, 1, 0, 0, 0};
      tbl[3]  = '{2, 1, 7, 0, 1, 1, 1, 0, 0, 0};
      tbl[4]  = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 0};
      tbl[5]  = '{5, 0, 0, 1, 1, 1, 0, 0, 1, 0};
      tbl[6]  = '{8, 1, 0, 2, 1, 1, 0, 1, 0, 0};
      tbl[7]  = '{8, 1, 0, 3, 1, 0, 0, 1, 0, 0};
      tbl[8]  = '{7, 1, 7, 3, 1, 0, 1, 1, 0, 0};
      tbl[9]  = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
      tbl[10] = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 0};
      for (int i = 0; i < 3; i++) begin
         rst_v[i] = 1'b1;
         ena_v[i] = 1'b0;
         ack_v[i] = 1'b0;
         st[i]    = '{0, 1'b0, 1'b0, 1'b0, 1'b1};
      end
      repeat (3) @(posedge clk);
      #1;

      // Default raster: divider cadence, line wrap and horizontal decode edges.
      do_reset(0, 3);
      for (int k = 1; k <= 800; k++) begin
         cycle(0, 1'b1, 1'b0, "d_run");
         if (k == 1)   chk("d_first_pce", int'(d_pce), 1);
         if (k == 2)   chk("d_second_pce", int'(d_pce), 0);
         if (k == 511) chk("d_hblank_255", int'(d_hb), 0);
         if (k == 512) chk("d_hblank_256", int'(d_hb), 1);
         if (k == 575) chk("d_hsync_287", int'(d_hs), 1);
         if (k == 576) chk("d_hsync_288", int'(d_hs), 0);
         if (k == 639) chk("d_hsync_319", int'(d_hs), 0);
         if (k == 640) chk("d_hsync_320", int'(d_hs), 1);
         if (k == 767) chk("d_h_383", int'(d_h), 383);
         if (k == 768) begin
            chk("d_h_wrap", int'(d_h), 0);
            chk("d_v_inc", int'(d_v), 1);
         end
      end

      // Freeze for 100 clks at htiming=100, then resume.
      for (int k = 0; k < 168; k++) cycle(0, 1'b1, 1'b0, "d_run");
      chk("d_h_at_100", int'(d_h), 100);
      for (int k = 0; k < 100; k++) begin
         cycle(0, 1'b0, 1'b0, "d_hold");
         if (d_pce) chk("d_hold_pce", int'(d_pce), 0);
      end
      chk("d_h_held", int'(d_h), 100);
      cycle(0, 1'b1, 1'b0, "d_resume");
      chk("d_resume_pce", int'(d_pce), 1);
      cycle(0, 1'b1, 1'b0, "d_resume");
      chk("d_h_101", int'(d_h), 101);

      // Mid-frame reset pulse.
      do_reset(0, 3);
      chk("d_rel_valid", int'(d_vv), 0);
      cycle(0, 1'b1, 1'b0, "d_post");
      chk("d_post_valid", int'(d_vv), 1);
      chk("d_post_h", int'(d_h), 0);
      chk("d_post_v", int'(d_v), 0);

      for (int k = 0; k < 1500; k++)
         cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), "d_rand");

      // Tiny raster: table of checkpoints then frame/valid cadence.
      do_reset(1, 2);
      for (int i = 0; i < 11; i++) begin
         for (int j = 0; j < tbl[i].adv; j++) cycle(1, tbl[i].ena, 1'b0, "a_tbl");
         ena_v[1] = tbl[i].ena;
         #1;
         chk($sformatf("a_tbl%0d.h", i), int'(a_h), tbl[i].h);
         chk($sformatf("a_tbl%0d.v", i), int'(a_v), tbl[i].v);
         chk($sformatf("a_tbl%0d.hsync", i), int'(a_hs), int'(tbl[i].hs));
         chk($sformatf("a_tbl%0d.vsync", i), int'(a_vs), int'(tbl[i].vs));
         chk($sformatf("a_tbl%0d.hblank", i), int'(a_hb), int'(tbl[i].hb));
         chk($sformatf("a_tbl%0d.vblank", i), int'(a_vb), int'(tbl[i].vb));
         chk($sformatf("a_tbl%0d.valid", i), int'(a_vv), int'(tbl[i].vv));
         chk($sformatf("a_tbl%0d.fstart", i), int'(a_fs), int'(tbl[i].fs));
      end
      fs_cnt   = 0;
      vv_cnt   = 0;
      first_fs = -1;
      last_fs  = -1;
      for (int k = 0; k < 64; k++) begin
         cycle(1, 1'b1, 1'b0, "a_run");
         if (a_fs) begin
            if (first_fs < 0) first_fs = k;
            last_fs = k;
            fs_cnt++;
         end
         if (a_vv) vv_cnt++;
      end
      chk("a_fs_count", fs_cnt, 2);
      chk("a_fs_period", last_fs - first_fs, 32);
      chk("a_valid_count", vv_cnt, 16);

      // Vblank interrupt: set, hold, ack, and ack colliding with set.
      do_reset(1, 2);
      for (int k = 0; k < 16; k++) cycle(1, 1'b1, 1'b0, "a_irq");
      chk("a_irq_set", int'(a_irq), int'(IRQ_EN));
      for (int k = 0; k < 5; k++) cycle(1, 1'b1, 1'b0, "a_irq");
      chk("a_irq_hold", int'(a_irq), int'(IRQ_EN));
      cycle(1, 1'b1, 1'b1, "a_irq_ack");
      chk("a_irq_acked", int'(a_irq), 0);
      cycle(1, 1'b1, 1'b0, "a_irq");
      for (int k = 0; k < 24; k++) cycle(1, 1'b1, 1'b0, "a_irq");
      chk("a_irq_pre_collide", int'(a_irq), 0);
      cycle(1, 1'b1, 1'b1, "a_irq_collide");
      chk("a_irq_collide", int'(a_irq), int'(IRQ_EN));

      // PIX_DIV=3 raster under random enable/acknowledge, with a reset midway.
      do_reset(2, 2);
      for (int k = 0; k < 1200; k++)
         cycle(2, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), "b_rand");
      do_reset(2, 1);
      for (int k = 0; k < 1200; k++)
         cycle(2, ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) == 0), "b_rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
